// File: rtl/calc_pkg.sv
// Shared response encoding, error codes and counter helpers for the calculator scoreboard.
// Latency: none (definitions only); backpressure: n/a.
package calc_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_INV  = 2'd2,
        RESP_IERR = 2'd3
    } resp_e;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_RESP    = 3'd1;
    localparam logic [2:0] ERR_DATA    = 3'd2;
    localparam logic [2:0] ERR_UNEXP   = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_OVF     = 3'd5;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/calc_sb_port.sv
// One scoreboard lane: in-order expected-response queue, head-age timer and compare.
// Latency: error registered 1 cycle after cause; backpressure: none, full queue reports overflow.
module calc_sb_port
    import calc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        ref_resp_i,
    input  logic [DATA_W-1:0] ref_data_i,
    input  logic [1:0]        duv_resp_i,
    input  logic [DATA_W-1:0] duv_data_i,
    output logic              err_vld_o,
    output logic [2:0]        err_code_o,
    output logic              err_ev_o,
    output logic              match_ev_o,
    output logic              pending_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);

    logic [1:0]        resp_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              err_vld_q;
    logic [2:0]        err_code_q, err_code_d;

    logic              ref_v, duv_v, empty, full, push, pop, ovf, timeout, drop, match;
    logic [1:0]        exp_resp;
    logic [DATA_W-1:0] exp_data;

    always_comb begin
        ref_v    = ref_resp_i != RESP_NONE;
        duv_v    = duv_resp_i != RESP_NONE;
        empty    = cnt_q == '0;
        full     = cnt_q == FULL_CNT;
        // An empty queue compares a same-cycle reference response directly.
        exp_resp = empty ? ref_resp_i : resp_mem_q[rd_ptr_q];
        exp_data = empty ? ref_data_i : data_mem_q[rd_ptr_q];
        pop      = duv_v && !empty;
        push     = ref_v && (duv_v ? !empty : !full);
        ovf      = ref_v && !duv_v && full;
        // An overflow in the timeout cycle defers the timeout by holding the timer.
        timeout  = !duv_v && !empty && !ovf && (tmr_q == TMAX);
        drop     = pop || timeout;

        match      = 1'b0;
        err_code_d = ERR_NONE;
        if (duv_v && empty && !ref_v) begin
            err_code_d = ERR_UNEXP;
        end else if (duv_v) begin
            if (exp_resp != duv_resp_i)
                err_code_d = ERR_RESP;
            else if (exp_resp == RESP_OK && exp_data != duv_data_i)
                err_code_d = ERR_DATA;
            else
                match = 1'b1;
        end else if (ovf) begin
            err_code_d = ERR_OVF;
        end else if (timeout) begin
            err_code_d = ERR_TIMEOUT;
        end

        rd_ptr_d = drop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        cnt_d    = cnt_q;
        if (push && !drop)
            cnt_d = cnt_q + (AW + 1)'(1);
        else if (!push && drop)
            cnt_d = cnt_q - (AW + 1)'(1);

        tmr_d = tmr_q;
        if (drop || empty)
            tmr_d = '0;
        else if (tmr_q != TMAX)
            tmr_d = tmr_q + TW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            tmr_q      <= '0;
            err_vld_q  <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            err_vld_q  <= err_code_d != ERR_NONE;
            err_code_q <= err_code_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            resp_mem_q[wr_ptr_q] <= ref_resp_i;
            data_mem_q[wr_ptr_q] <= ref_data_i;
        end
    end

    assign err_vld_o  = err_vld_q;
    assign err_code_o = err_code_q;
    assign err_ev_o   = err_code_d != ERR_NONE;
    assign match_ev_o = match;
    assign pending_o  = !empty;

endmodule

// File: rtl/calc_scoreboard.sv
// Multi-port calculator scoreboard: per-port in-order compare plus saturating global counters.
// Latency: errors and counters update 1 cycle after cause; backpressure: none.
module calc_scoreboard
    import calc_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                        c_clk,
    input  logic                        reset_n,
    input  logic [2*NUM_PORTS-1:0]      ref_resp,
    input  logic [DATA_W*NUM_PORTS-1:0] ref_data,
    input  logic [2*NUM_PORTS-1:0]      duv_resp,
    input  logic [DATA_W*NUM_PORTS-1:0] duv_data,
    output logic [NUM_PORTS-1:0]        err_valid,
    output logic [3*NUM_PORTS-1:0]      err_code,
    output logic [CNT_W-1:0]            match_cnt,
    output logic [CNT_W-1:0]            err_cnt,
    output logic [NUM_PORTS-1:0]        pending
);

    logic [NUM_PORTS-1:0] err_ev, match_ev;
    logic [CNT_W-1:0]     err_sum, match_sum;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d, match_cnt_q, match_cnt_d;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        calc_sb_port #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .TIMEOUT (TIMEOUT)
        ) u_port (
            .clk_i      (c_clk),
            .rst_ni     (reset_n),
            .ref_resp_i (ref_resp[2*p +: 2]),
            .ref_data_i (ref_data[DATA_W*p +: DATA_W]),
            .duv_resp_i (duv_resp[2*p +: 2]),
            .duv_data_i (duv_data[DATA_W*p +: DATA_W]),
            .err_vld_o  (err_valid[p]),
            .err_code_o (err_code[3*p +: 3]),
            .err_ev_o   (err_ev[p]),
            .match_ev_o (match_ev[p]),
            .pending_o  (pending[p])
        );
    end

    always_comb begin
        err_sum   = '0;
        match_sum = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            err_sum   = err_sum + CNT_W'(err_ev[p]);
            match_sum = match_sum + CNT_W'(match_ev[p]);
        end
        err_cnt_d   = sat_add(err_cnt_q, err_sum);
        match_cnt_d = sat_add(match_cnt_q, match_sum);
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign err_cnt   = err_cnt_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_calc_scoreboard.sv
// Self-checking bench for calc_scoreboard: behavioural queue model feeds a per-cycle expectation queue.
module tb_calc_scoreboard;

    localparam int NP      = 4;
    localparam int DW      = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic [NP-1:0]   vld;
        logic [3*NP-1:0] code;
        logic [15:0]     mc;
        logic [15:0]     ec;
        logic [NP-1:0]   pend;
    } exp_t;

    logic               c_clk   = 1'b0;
    logic               reset_n = 1'b1;
    logic [2*NP-1:0]    ref_resp = '0;
    logic [DW*NP-1:0]   ref_data = '0;
    logic [2*NP-1:0]    duv_resp = '0;
    logic [DW*NP-1:0]   duv_data = '0;
    logic [NP-1:0]      err_valid;
    logic [3*NP-1:0]    err_code;
    logic [15:0]        match_cnt;
    logic [15:0]        err_cnt;
    logic [NP-1:0]      pending;

    int n_checks = 0;
    int n_errs   = 0;
    int n_to     = 0;

    exp_t         exp_q [$];
    logic [DW+1:0] mq [NP][$];
    int           mtmr [NP];
    int           mcnt, ecnt;

    calc_scoreboard #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .c_clk     (c_clk),
        .reset_n   (reset_n),
        .ref_resp  (ref_resp),
        .ref_data  (ref_data),
        .duv_resp  (duv_resp),
        .duv_data  (duv_data),
        .err_valid (err_valid),
        .err_code  (err_code),
        .match_cnt (match_cnt),
        .err_cnt   (err_cnt),
        .pending   (pending)
    );

    always #5 c_clk = ~c_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) begin
            mq[p].delete();
            mtmr[p] = 0;
        end
        mcnt = 0;
        ecnt = 0;
        exp_q.delete();
    endfunction

    function automatic exp_t model_cycle(input logic [2*NP-1:0] rr, input logic [DW*NP-1:0] rd,
                                         input logic [2*NP-1:0] dr, input logic [DW*NP-1:0] dd);
        exp_t e;
        e = '0;
        for (int p = 0; p < NP; p++) begin
            logic [1:0]    r    = rr[2*p +: 2];
            logic [1:0]    d    = dr[2*p +: 2];
            logic [DW-1:0] rdat = rd[DW*p +: DW];
            logic [DW-1:0] ddat = dd[DW*p +: DW];
            logic [2:0]    c    = 3'd0;
            int            sz   = mq[p].size();
            logic [DW+1:0] hd;
            if (d != 2'd0) begin
                if (sz == 0 && r == 2'd0) begin
                    c = 3'd3;
                end else begin
                    if (sz == 0) begin
                        hd = {r, rdat};
                    end else begin
                        hd = mq[p].pop_front();
                        if (r != 2'd0) mq[p].push_back({r, rdat});
                    end
                    if (hd[DW+1:DW] != d) c = 3'd1;
                    else if (d == 2'd1 && hd[DW-1:0] != ddat) c = 3'd2;
                    else mcnt++;
                    mtmr[p] = 0;
                end
            end else begin
                bit ovf = (r != 2'd0) && (sz == DEPTH);
                bit to  = (sz != 0) && (mtmr[p] >= TIMEOUT) && !ovf;
                if (ovf) c = 3'd5;
                else if (to) begin
                    c = 3'd4;
                    void'(mq[p].pop_front());
                end
                if (r != 2'd0 && !ovf) mq[p].push_back({r, rdat});
                if (to || sz == 0) mtmr[p] = 0;
                else if (mtmr[p] < TIMEOUT) mtmr[p]++;
            end
            e.vld[p]       = c != 3'd0;
            e.code[3*p +: 3] = c;
            if (c != 3'd0) ecnt++;
        end
        if (mcnt > 16'hFFFF) mcnt = 16'hFFFF;
        if (ecnt > 16'hFFFF) ecnt = 16'hFFFF;
        e.mc = 16'(mcnt);
        e.ec = 16'(ecnt);
        for (int p = 0; p < NP; p++) e.pend[p] = mq[p].size() != 0;
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        check("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("err_valid", 32'(err_valid), 32'(e.vld));
        check("pending", 32'(pending), 32'(e.pend));
        check("match_cnt", 32'(match_cnt), 32'(e.mc));
        check("err_cnt", 32'(err_cnt), 32'(e.ec));
        for (int p = 0; p < NP; p++)
            if (e.vld[p])
                check($sformatf("err_code_p%0d", p), 32'(err_code[3*p +: 3]), 32'(e.code[3*p +: 3]));
        if (err_valid[0] && err_code[2:0] == 3'd4) n_to++;
    endtask

    task automatic step(input logic [2*NP-1:0] rr, input logic [DW*NP-1:0] rd,
                        input logic [2*NP-1:0] dr, input logic [DW*NP-1:0] dd);
        ref_resp = rr;
        ref_data = rd;
        duv_resp = dr;
        duv_data = dd;
        exp_q.push_back(model_cycle(rr, rd, dr, dd));
        @(posedge c_clk);
        #1;
        ref_resp = '0;
        duv_resp = '0;
        compare_out();
    endtask

    task automatic port_step(input int p, input logic [1:0] r, input logic [DW-1:0] rdat,
                             input logic [1:0] d, input logic [DW-1:0] ddat);
        logic [2*NP-1:0]  rr = '0;
        logic [2*NP-1:0]  dr = '0;
        logic [DW*NP-1:0] rd = '0;
        logic [DW*NP-1:0] dd = '0;
        rr[2*p +: 2]   = r;
        rd[DW*p +: DW] = rdat;
        dr[2*p +: 2]   = d;
        dd[DW*p +: DW] = ddat;
        step(rr, rd, dr, dd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, '0);
    endtask

    // Reset lands mid-cycle so the asynchronous clear is visible before any edge.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_err_valid", 32'(err_valid), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_match_cnt", 32'(match_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        @(negedge c_clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [2*NP-1:0]  rr, dr;
        logic [DW*NP-1:0] rd, dd;

        do_reset();

        // Single match after a three-cycle wait.
        port_step(1, 2'd1, 32'h5, 2'd0, 32'h0);
        idle(2);
        port_step(1, 2'd0, 32'h0, 2'd1, 32'h5);
        check("p1_match_cnt", 32'(match_cnt), 32'd1);
        check("p1_no_err", 32'(err_valid), 32'd0);

        // Data mismatch.
        port_step(2, 2'd1, 32'hA, 2'd0, 32'h0);
        port_step(2, 2'd0, 32'h0, 2'd1, 32'hB);
        check("p2_err_valid", 32'(err_valid[2]), 32'd1);
        check("p2_code", 32'(err_code[8:6]), 32'd2);
        check("p2_err_cnt", 32'(err_cnt), 32'd1);

        // Unexpected DUV response.
        port_step(3, 2'd0, 32'h0, 2'd2, 32'h0);
        check("p3_code", 32'(err_code[11:9]), 32'd3);
        check("p3_pending", 32'(pending[3]), 32'd0);

        // Response mismatch, then data ignored for a non-success response.
        port_step(0, 2'd2, 32'h1, 2'd0, 32'h0);
        port_step(0, 2'd0, 32'h0, 2'd3, 32'h1);
        check("p0_resp_code", 32'(err_code[2:0]), 32'd1);
        port_step(0, 2'd2, 32'h1, 2'd0, 32'h0);
        port_step(0, 2'd0, 32'h0, 2'd2, 32'h77);
        check("p0_inv_match", 32'(match_cnt), 32'd2);

        // Bypass compare on all ports at once.
        step(8'h55, {4{32'h1234}}, 8'h55, {4{32'h1234}});
        check("all_match", 32'(match_cnt), 32'd6);
        check("all_pend", 32'(pending), 32'd0);

        // Simultaneous push/pop on a non-empty queue.
        port_step(2, 2'd1, 32'h10, 2'd0, 32'h0);
        port_step(2, 2'd1, 32'h20, 2'd1, 32'h10);
        check("p2_swap_pend", 32'(pending[2]), 32'd1);
        port_step(2, 2'd0, 32'h0, 2'd1, 32'h20);
        check("p2_swap_match", 32'(match_cnt), 32'd8);

        // DUV pop in the timeout cycle wins.
        port_step(1, 2'd1, 32'h7, 2'd0, 32'h0);
        idle(TIMEOUT);
        port_step(1, 2'd0, 32'h0, 2'd1, 32'h7);
        check("p1_late_no_err", 32'(err_valid), 32'd0);
        check("p1_late_match", 32'(match_cnt), 32'd9);

        // Overflow on the fifth push, then four timeouts.
        for (int i = 0; i < 5; i++) port_step(0, 2'd1, 32'(i), 2'd0, 32'h0);
        check("p0_ovf_code", 32'(err_code[2:0]), 32'd5);
        n_to = 0;
        for (int i = 0; i < 5 * (TIMEOUT + 1) && pending[0]; i++) idle(1);
        check("p0_timeouts", 32'(n_to), 32'd4);
        check("p0_drained", 32'(pending[0]), 32'd0);

        // Random traffic with a small data range so matches and mismatches both occur.
        for (int c = 0; c < 400; c++) begin
            rr = '0; dr = '0; rd = '0; dd = '0;
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 99) < 45) rr[2*p +: 2] = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 99) < 40) dr[2*p +: 2] = 2'($urandom_range(1, 3));
                rd[DW*p +: DW] = DW'($urandom_range(0, 3));
                dd[DW*p +: DW] = DW'($urandom_range(0, 3));
            end
            step(rr, rd, dr, dd);
        end

        // Outstanding entries are discarded silently by reset.
        do_reset();
        for (int i = 0; i < 3; i++) port_step(1, 2'd1, 32'(i), 2'd0, 32'h0);
        check("p1_three_pend", 32'(pending[1]), 32'd1);
        do_reset();
        idle(TIMEOUT + 8);
        check("post_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("post_rst_pend", 32'(pending), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errs);
        $fatal(1, "watchdog");
    end

endmodule
